mem_resp_unit: RTL and testbench

MEM_RESP_UNIT -- requirements
Module: mem_resp_unit

---
 rtl/mem_resp_unit.sv | 114 +++++++++++
 tb/tb_mem_resp_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_resp_unit.sv
// Multi-cycle memory responder: accepts one read/write request, holds the requester
// with stall for LATENCY-1 cycles, then pulses done with read data or a misalignment error.
module mem_resp_unit #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [2:0] LAST  = 3'(LATENCY - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic [ADDR_W:0]   req_addr;
  logic              req_wr;
  logic [15:0]       req_data;
  logic [15:0]       mem [DEPTH];

  logic              accept;
  logic              complete;
  logic [ADDR_W:0]   cur_addr;
  logic              cur_wr;
  logic [15:0]       cur_data;
  logic              wr_commit;
  logic [15:0]       rd_word;
  logic              unused_addr_hi;

  // Byte-address bits above the word index never matter: the index wraps.
  assign unused_addr_hi = ^addr[15:ADDR_W+1];

  assign accept = en && (state == IDLE || state == DONE);

  // With a single-edge latency the request completes on its acceptance edge, so the
  // live inputs stand in for the not-yet-loaded request registers.
  always_comb begin
    cur_addr  = req_addr;
    cur_wr    = req_wr;
    cur_data  = req_data;
    complete  = (state == BUSY) && (cnt == LAST);
    if (LATENCY == 1) begin
      cur_addr = addr[ADDR_W:0];
      cur_wr   = wr;
      cur_data = data_in;
      complete = accept;
    end
    wr_commit = complete && cur_wr && !cur_addr[0];
    rd_word   = (cur_wr || cur_addr[0]) ? 16'h0000 : mem[cur_addr[ADDR_W:1]];
  end

  // NOTE: storage has no reset; its power-up contents are undefined and reset must not
  // clear it. A reset mid-request drops state to IDLE, which removes wr_commit.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[cur_addr[ADDR_W:1]] <= cur_data;
  end

  // NOTE: every register here uses non-blocking assignment so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
      req_wr   <= 1'b0;
      req_data <= '0;
      stall    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else if (complete) begin
      if (accept) begin
        req_addr <= addr[ADDR_W:0];
        req_wr   <= wr;
        req_data <= data_in;
      end
      state    <= DONE;
      cnt      <= '0;
      stall    <= 1'b0;
      done     <= 1'b1;
      err      <= cur_addr[0];
      data_out <= rd_word;
    end else if (accept) begin
      req_addr <= addr[ADDR_W:0];
      req_wr   <= wr;
      req_data <= data_in;
      state    <= BUSY;
      cnt      <= 3'd1;
      stall    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 3'd1;
    end else begin
      state    <= IDLE;
      stall    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_mem_resp_unit.sv
// Directed bench for mem_resp_unit: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 instance for the streaming case, both checked with immediate assertions.
module tb_mem_resp_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, din = '0;
  logic        stall, done, err;
  logic [15:0] dout;

  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, din1 = '0;
  logic        stall1, done1, err1;
  logic [15:0] dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_resp_unit #(.LATENCY(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(din),
    .stall(stall), .done(done), .data_out(dout), .err(err)
  );

  mem_resp_unit #(.LATENCY(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .wr(wr1), .addr(addr1), .data_in(din1),
    .stall(stall1), .done(done1), .data_out(dout1), .err(err1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    check({tag, " idle stall"}, 16'(stall), 16'h0);
    check({tag, " idle done"},  16'(done),  16'h0);
    check({tag, " idle err"},   16'(err),   16'h0);
    check({tag, " idle data"},  dout,       16'h0000);
  endtask

  // Called at a negedge; drives a request, scrambles the inputs after acceptance, checks
  // three stall cycles and then the done cycle. Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_d, input logic exp_e,
                        input logic poke, input logic [15:0] poke_a);
    en = 1'b1; wr = w; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; wr = ~w; addr = 16'hFFFF; din = 16'h0BAD;
    for (int i = 0; i < 3; i++) begin
      check({tag, " stall"}, 16'(stall), 16'h1);
      check({tag, " no done"}, 16'(done), 16'h0);
      if (poke && i == 0) begin
        en = 1'b1; wr = 1'b1; addr = poke_a; din = 16'hDEAD;
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " done"},  16'(done),  16'h1);
    check({tag, " stall end"}, 16'(stall), 16'h0);
    check({tag, " err"},   16'(err),   16'(exp_e));
    if (!w) check({tag, " data"}, dout, exp_d);
  endtask

  initial begin
    #3;
    check("reset stall", 16'(stall), 16'h0);
    check("reset done",  16'(done),  16'h0);
    check("reset err",   16'(err),   16'h0);
    check("reset data",  dout,       16'h0000);

    // Release reset and accept at the very next rising edge.
    @(negedge clk);
    rst = 1'b1;
    run_op("wr 0010", 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0);
    idle_chk("after wr 0010");
    run_op("rd 0010", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0);
    idle_chk("after rd 0010");

    run_op("rd 0011 misaligned", 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0);
    idle_chk("after misaligned rd");
    run_op("wr 0011 misaligned", 1'b1, 16'h0011, 16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0);
    idle_chk("after misaligned wr");
    run_op("rd 0010 again", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0);
    idle_chk("after rd 0010 again");

    run_op("wr 0200 wrap", 1'b1, 16'h0200, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0);
    idle_chk("after wr 0200");
    run_op("rd 0000 wrap", 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    idle_chk("after rd 0000");

    // Back-to-back: read issued in the write's done cycle; BUSY poke at 0x0010 ignored.
    run_op("wr 0040 b2b", 1'b1, 16'h0040, 16'h7777, 16'h0000, 1'b0, 1'b1, 16'h0010);
    run_op("rd 0040 b2b", 1'b0, 16'h0040, 16'h0000, 16'h7777, 1'b0, 1'b0, 16'h0);
    idle_chk("after b2b");
    run_op("rd 0010 after poke", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0);
    idle_chk("after poke check");

    // Abort an in-flight write with reset.
    run_op("wr 0020", 1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h0);
    idle_chk("after wr 0020");
    en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'hAAAA;
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 check("abort in flight stall", 16'(stall), 16'h1);
    #1 rst = 1'b0;
    #1;
    check("abort stall", 16'(stall), 16'h0);
    check("abort done",  16'(done),  16'h0);
    check("abort err",   16'(err),   16'h0);
    check("abort data",  dout,       16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post abort done",  16'(done),  16'h0);
      check("post abort stall", 16'(stall), 16'h0);
    end
    run_op("rd 0020 after abort", 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, 1'b0, 16'h0);
    idle_chk("after abort read");

    // LATENCY=1 instance: streaming with en held high.
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0002; din1 = 16'h0101;
    @(negedge clk);
    check("l1 wr a done",  16'(done1),  16'h1);
    check("l1 wr a stall", 16'(stall1), 16'h0);
    wr1 = 1'b1; addr1 = 16'h0004; din1 = 16'h0202;
    @(negedge clk);
    check("l1 wr b done",  16'(done1),  16'h1);
    check("l1 wr b stall", 16'(stall1), 16'h0);
    wr1 = 1'b0; addr1 = 16'h0002;
    @(negedge clk);
    check("l1 rd a done",  16'(done1),  16'h1);
    check("l1 rd a stall", 16'(stall1), 16'h0);
    check("l1 rd a data",  dout1,       16'h0101);
    addr1 = 16'h0004;
    @(negedge clk);
    check("l1 rd b done",  16'(done1),  16'h1);
    check("l1 rd b stall", 16'(stall1), 16'h0);
    check("l1 rd b data",  dout1,       16'h0202);
    addr1 = 16'h0003;
    @(negedge clk);
    check("l1 rd mis done", 16'(done1),  16'h1);
    check("l1 rd mis err",  16'(err1),   16'h1);
    check("l1 rd mis data", dout1,       16'h0000);
    check("l1 rd mis stall", 16'(stall1), 16'h0);
    en1 = 1'b0;
    @(negedge clk);
    check("l1 idle done",  16'(done1),  16'h0);
    check("l1 idle err",   16'(err1),   16'h0);
    check("l1 idle data",  dout1,       16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
